uart_tx_frame_ctrl: RTL and testbench
=====================================

Name: uart_tx_frame_ctrl

Overview:
Transmit-side frame sequencer for the UART. It accepts a byte over a valid/ready handshake and serialises it as start bit, data LSB-first, optional parity bit, then stop bit(s), each held for a fixed number of clocks. It computes the parity bit internally using the team's standard parity encoding and drives the idle-high serial line. It sits between the TX holding logic (FIFO or host register) and the pad.

Parameters:
CLKS_PER_BIT, 16, clocks per serial bit period (>=2); bit-period counter width = clog2(CLKS_PER_BIT)
DATA_BITS, 8, data bits per frame (5..8)
STOP_BITS, 1, stop bits per frame (1 or 2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, asynchronous and active-high
tx_data  input  DATA_BITS  byte to send, sampled on accept
tx_valid  input  1  requester has a byte
tx_ready  output  1  block can accept; accept = tx_valid & tx_ready at a clk edge
parity_type  input  2  01 = ODD, 10 = EVEN, 00/11 = no parity bit; sampled on accept
tx  output  1  serial line, idle high
tx_busy  output  1  frame in progress
tx_done  output  1  one-cycle pulse at frame end

Behaviour:
- Reset (async assert): state IDLE; tx=1, tx_ready=1, tx_busy=0, tx_done=0; counters and shift register cleared. Reset mid-frame aborts immediately, and tx returns to 1 without waiting for a clock edge.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx=1, tx_ready=1, tx_busy=0. On accept, latch tx_data into the shift register and parity_type into the config register. Compute par_bit from the latched data: ODD -> ~^data (total ones odd); EVEN -> ^data (total ones even). Then go to START.
- After accept, from the next cycle: tx_ready=0, tx_busy=1.
- START: tx=0 for CLKS_PER_BIT clocks, then go to DATA.
- DATA: tx = current LSB. Shift right every CLKS_PER_BIT clocks. A bit index counter runs 0..DATA_BITS-1. After the last bit, go to PARITY if the latched type is 01 or 10; otherwise go to STOP.
- PARITY: tx=par_bit for CLKS_PER_BIT clocks, then go to STOP.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT clocks, then go to IDLE.
- On entry to IDLE: tx_done=1 for exactly one cycle; tx_ready=1 and tx_busy=0 in that same cycle.
- Bit timing: a single bit-period counter counts 0..CLKS_PER_BIT-1 and wraps at terminal count, at which point the state or bit advances. The counter resets to 0 on every state change.
- Frame length from the accept edge to the tx_done cycle: (1 + DATA_BITS + P + STOP_BITS)*CLKS_PER_BIT clocks, where P = 1 if parity is enabled, else 0.
- Back-to-back: tx_valid held high during the tx_done cycle is accepted in that cycle. The next start bit then follows the last stop bit with no extra idle cycle.
- tx_valid while busy is ignored; no byte is lost because tx_ready=0 back-pressures the requester.
- Changes to tx_data or parity_type mid-frame have no effect on the current frame.
- tx_valid asserted in the same cycle that reset deasserts is legal and is accepted on the first clk edge.

Test Plan:
- Reset values: assert rst with tx_valid=1 -> tx=1, tx_ready=1, tx_busy=0, tx_done=0. Release rst and hold tx_valid=0 -> outputs unchanged for 100 clocks.
- EVEN frame, CLKS_PER_BIT=4, DATA_BITS=8, STOP_BITS=1: tx_data=0xA5, parity_type=10 -> tx shows start 0, then 1,0,1,0,0,1,0,1, then parity 0, then stop 1, each bit 4 clocks wide. tx_done pulses at 44 clocks after accept.
- ODD frame: tx_data=0x07, parity_type=01 -> parity bit 0. Repeat with parity_type=10 -> parity bit 1. With parity_type=00 or 11 -> no parity bit, and tx_done at 40 clocks.
- Back-to-back with STOP_BITS=2: hold tx_valid high and send 0x55 then 0xAA -> second start bit falling edge occurs exactly 8 clocks after the first frame's stop bits began. tx_ready is high for exactly one cycle between the two frames.
- Mid-frame disturbance: change tx_data to 0xFF and parity_type from 10 to 01 during the DATA state of a 0x3C frame -> serial bits still encode 0x3C with even parity bit 0.
- Reset mid-frame: assert rst during the PARITY state -> tx goes to 1 asynchronously, busy drops, and no tx_done pulse follows. After release, a new frame with 0x81 transmits correctly.

Source files
------------

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit frame sequencer: start bit, LSB-first data, optional parity, stop bit(s).
// state  | meaning
// IDLE   | line high, ready for a byte
// START  | start bit (low)
// DATA   | data bits, LSB first
// PARITY | parity bit
// STOP   | stop bit(s), high
module uart_tx_frame_ctrl #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   input  logic [1:0]           parity_type,
   output logic                 tx,
   output logic                 tx_busy,
   output logic                 tx_done
);
   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_DONE  = CNT_W'(CLKS_PER_BIT - 2);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
   localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t               state;
   logic [CNT_W-1:0]     cnt;
   logic [IDX_W-1:0]     bit_idx;
   logic [DATA_BITS-1:0] shreg;
   logic [1:0]           par_cfg;
   logic                 par_bit;
   logic                 par_en;

   assign par_en = ^par_cfg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         tx       <= 1'b1;
         tx_ready <= 1'b1;
         tx_busy  <= 1'b0;
         tx_done  <= 1'b0;
         cnt      <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         par_cfg  <= '0;
         par_bit  <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (tx_valid && tx_ready) begin
                  shreg    <= tx_data;
                  par_cfg  <= parity_type;
                  par_bit  <= (parity_type == 2'b01) ? ~^tx_data : ^tx_data;
                  state    <= S_START;
                  tx       <= 1'b0;
                  tx_ready <= 1'b0;
                  tx_busy  <= 1'b1;
                  cnt      <= '0;
                  bit_idx  <= '0;
               end
            end
            S_START: begin
               if (cnt == CNT_LAST) begin
                  state <= S_DATA;
                  tx    <= shreg[0];
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DATA: begin
               if (cnt == CNT_LAST) begin
                  cnt <= '0;
                  if (bit_idx == IDX_LAST) begin
                     bit_idx <= '0;
                     if (par_en) begin
                        state <= S_PARITY;
                        tx    <= par_bit;
                     end else begin
                        state <= S_STOP;
                        tx    <= 1'b1;
                     end
                  end else begin
                     shreg   <= shreg >> 1;
                     tx      <= shreg[1];
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_PARITY: begin
               if (cnt == CNT_LAST) begin
                  state <= S_STOP;
                  tx    <= 1'b1;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_STOP: begin
               // The done cycle is the last clock of the final stop bit, so a
               // back-to-back accept starts the next frame with no idle gap.
               if (bit_idx == STOP_LAST && cnt == CNT_DONE) begin
                  state    <= S_IDLE;
                  tx_done  <= 1'b1;
                  tx_ready <= 1'b1;
                  tx_busy  <= 1'b0;
                  cnt      <= '0;
                  bit_idx  <= '0;
               end else if (cnt == CNT_LAST) begin
                  cnt     <= '0;
                  bit_idx <= bit_idx + 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state    <= S_IDLE;
               tx       <= 1'b1;
               tx_ready <= 1'b1;
               tx_busy  <= 1'b0;
               cnt      <= '0;
               bit_idx  <= '0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Bench for uart_tx_frame_ctrl: one- and two-stop-bit instances against a frame-queue model.
module tb_uart_tx_frame_ctrl;
   localparam int CPB = 4;
   localparam int DB  = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b1;
   logic [1:0] parity_type = 2'b00;
   logic       tx0, ready0, busy0, done0;
   logic       tx1, ready1, busy1, done1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   uart_tx_frame_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .STOP_BITS(1)) u_dut0 (
      .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(ready0),
      .parity_type(parity_type), .tx(tx0), .tx_busy(busy0), .tx_done(done0));

   uart_tx_frame_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .STOP_BITS(2)) u_dut1 (
      .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(ready1),
      .parity_type(parity_type), .tx(tx1), .tx_busy(busy1), .tx_done(done1));

   task automatic check_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: each accepted byte becomes a queue of per-clock line values,
   // bit [0] = tx, bit [1] = marks the done cycle (last clock of the frame).
   typedef bit [1:0] ent_q_t[$];
   ent_q_t     mq[2];
   logic [1:0] e_tx = 2'b11, e_busy = 2'b00, e_ready = 2'b11, e_done = 2'b00;

   function automatic ent_q_t build_frame(input logic [7:0] d, input logic [1:0] pt,
                                          input int stop_bits);
      ent_q_t q;
      bit     b[$];
      bit [1:0] last;
      int     ones = 0;
      b.push_back(1'b0);
      for (int i = 0; i < DB; i++) begin
         b.push_back(d[i]);
         ones += int'(d[i]);
      end
      if (pt == 2'b01) b.push_back((ones % 2) == 0);
      else if (pt == 2'b10) b.push_back((ones % 2) == 1);
      for (int s = 0; s < stop_bits; s++) b.push_back(1'b1);
      foreach (b[k]) for (int c = 0; c < CPB; c++) q.push_back({1'b0, b[k]});
      last = q.pop_back();
      last[1] = 1'b1;
      q.push_back(last);
      return q;
   endfunction

   initial begin
      bit [1:0] ent;
      forever begin
         @(posedge clk or posedge rst);
         for (int i = 0; i < 2; i++) begin
            if (rst) begin
               mq[i].delete();
               e_tx[i] = 1'b1; e_busy[i] = 1'b0; e_ready[i] = 1'b1; e_done[i] = 1'b0;
            end else begin
               if (e_ready[i] && tx_valid) mq[i] = build_frame(tx_data, parity_type, i + 1);
               if (mq[i].size() > 0) begin
                  ent = mq[i].pop_front();
                  e_tx[i] = ent[0]; e_done[i] = ent[1]; e_busy[i] = !ent[1]; e_ready[i] = ent[1];
               end else begin
                  e_tx[i] = 1'b1; e_busy[i] = 1'b0; e_ready[i] = 1'b1; e_done[i] = 1'b0;
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         check_bit("m0_tx", tx0, e_tx[0]);
         check_bit("m0_ready", ready0, e_ready[0]);
         check_bit("m0_busy", busy0, e_busy[0]);
         check_bit("m0_done", done0, e_done[0]);
         check_bit("m1_tx", tx1, e_tx[1]);
         check_bit("m1_ready", ready1, e_ready[1]);
         check_bit("m1_busy", busy1, e_busy[1]);
         check_bit("m1_done", done1, e_done[1]);
      end
   end

   task automatic wait_idle();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(ready0 && ready1 && !busy0 && !busy1) && n < 400);
      if (n >= 400) check_bit("idle_timeout", ready0 & ready1, 1'b1);
   endtask

   // Sends one byte on instance 0 and records tx per clock; cycle 1 follows the accept edge.
   task automatic send_frame(input logic [7:0] d, input logic [1:0] pt, input bit disturb,
                             output int len, output logic [127:0] samp);
      wait_idle();
      tx_data = d; parity_type = pt; tx_valid = 1'b1;
      len = 0;
      samp = '1;
      for (int c = 1; c < 128 && len == 0; c++) begin
         @(negedge clk);
         if (c == 1) tx_valid = 1'b0;
         if (disturb && c == 12) begin
            tx_data = 8'hFF; parity_type = 2'b01;
         end
         samp[c] = tx0;
         if (done0) len = c;
      end
   endtask

   task automatic check_frame(input string name, input logic [127:0] samp, input int len,
                              input logic [7:0] d, input int par, input int exp_len);
      logic [7:0] dec;
      for (int j = 0; j < DB; j++) dec[j] = samp[6 + 4 * j];
      check_bit({name, "_start"}, samp[2], 1'b0);
      check_int({name, "_data"}, int'(dec), int'(d));
      if (par >= 0) check_bit({name, "_parity"}, samp[38], par[0]);
      check_int({name, "_len"}, len, exp_len);
   endtask

   typedef struct {
      logic [7:0] data;
      logic [1:0] pt;
      int         par;
      int         len;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int          len, n_done, rdy_cnt, fall, n_idle_bad;
      logic [127:0] samp;
      logic [127:0] samp1;

      vecs[0] = '{8'hA5, 2'b10,  0, 44};
      vecs[1] = '{8'h07, 2'b01,  0, 44};
      vecs[2] = '{8'h07, 2'b10,  1, 44};
      vecs[3] = '{8'h07, 2'b00, -1, 40};
      vecs[4] = '{8'h07, 2'b11, -1, 40};
      vecs[5] = '{8'h81, 2'b01,  1, 44};
      vecs[6] = '{8'hFF, 2'b10,  0, 44};
      vecs[7] = '{8'h00, 2'b01,  1, 44};

      // reset held with tx_valid high
      @(negedge clk);
      check_bit("rst_tx", tx0, 1'b1);
      check_bit("rst_ready", ready0, 1'b1);
      check_bit("rst_busy", busy0, 1'b0);
      check_bit("rst_done", done0, 1'b0);
      @(negedge clk);
      #1 rst = 1'b0;
      tx_valid = 1'b0;
      n_idle_bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (!(tx0 && ready0 && !busy0 && !done0 && tx1 && ready1 && !busy1 && !done1))
            n_idle_bad++;
      end
      check_int("idle_hold", n_idle_bad, 0);

      for (int v = 0; v < 8; v++) begin
         send_frame(vecs[v].data, vecs[v].pt, 1'b0, len, samp);
         check_frame($sformatf("vec%0d", v), samp, len, vecs[v].data, vecs[v].par, vecs[v].len);
      end

      // mid-frame changes to data and parity type must not leak into the frame
      send_frame(8'h3C, 2'b10, 1'b1, len, samp);
      check_frame("disturb", samp, len, 8'h3C, 0, 44);

      // back-to-back on the two-stop-bit instance
      wait_idle();
      tx_data = 8'h55; parity_type = 2'b10; tx_valid = 1'b1;
      rdy_cnt = 0; fall = 0; samp1 = '1;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         if (c == 1) tx_data = 8'hAA;
         samp1[c] = tx1;
         if (c >= 2 && c <= 52 && ready1) rdy_cnt++;
         if (c >= 41 && fall == 0 && !tx1) fall = c;
         if (c == 50) tx_valid = 1'b0;
      end
      check_bit("b2b_parity", samp1[40], 1'b0);
      check_bit("b2b_stop_start", samp1[41], 1'b1);
      check_int("b2b_fall", fall, 49);
      check_int("b2b_ready_cycles", rdy_cnt, 1);

      // reset during the parity bit
      wait_idle();
      tx_data = 8'h81; parity_type = 2'b10; tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      repeat (37) @(negedge clk);
      check_bit("rstmid_parity_low", tx0, 1'b0);
      #2 rst = 1'b1;
      #1;
      check_bit("rstmid_async_tx", tx0, 1'b1);
      check_bit("rstmid_async_busy", busy0, 1'b0);
      check_bit("rstmid_async_ready", ready0, 1'b1);
      @(negedge clk);
      @(negedge clk);
      #1 rst = 1'b0;
      n_done = 0;
      repeat (30) begin
         @(negedge clk);
         if (done0 || done1) n_done++;
      end
      check_int("rstmid_no_done", n_done, 0);
      send_frame(8'h81, 2'b01, 1'b0, len, samp);
      check_frame("after_rst", samp, len, 8'h81, 1, 44);

      // random traffic with occasional resets, checked by the model
      for (int c = 0; c < 2500; c++) begin
         @(negedge clk);
         tx_valid    = ($urandom_range(0, 3) != 0);
         tx_data     = 8'($urandom);
         parity_type = 2'($urandom);
         if (rst) begin
            #1 rst = 1'b0;
         end else if ($urandom_range(0, 599) == 0) begin
            #1 rst = 1'b1;
         end
      end
      tx_valid = 1'b0;
      #1 rst = 1'b0;
      wait_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
